// File: rtl/alu_rs.sv
// Integer ALU reservation station: buffers dispatched ops until both operands are
// resolved via CDB snooping, then issues the lowest-index ready entry each cycle.
module alu_rs #(
  parameter int RS_BIT  = 3,
  parameter int ROB_BIT = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               rob_clear_up,
  input  logic               in_valid,
  input  logic [2:0]         in_op,
  input  logic [6:0]         in_op_type,
  input  logic               in_op_addition,
  input  logic [31:0]        in_vi,
  input  logic [31:0]        in_vj,
  input  logic               in_qi_valid,
  input  logic               in_qj_valid,
  input  logic [ROB_BIT-1:0] in_qi,
  input  logic [ROB_BIT-1:0] in_qj,
  input  logic [ROB_BIT-1:0] in_rob_entry,
  output logic               full,
  input  logic               alu_cdb_valid,
  input  logic [ROB_BIT-1:0] alu_cdb_entry,
  input  logic [31:0]        alu_cdb_value,
  input  logic               lsb_cdb_valid,
  input  logic [ROB_BIT-1:0] lsb_cdb_entry,
  input  logic [31:0]        lsb_cdb_value,
  output logic               alu_valid,
  output logic [31:0]        alu_vi,
  output logic [31:0]        alu_vj,
  output logic [2:0]         alu_op,
  output logic [6:0]         alu_op_type,
  output logic               alu_op_addition,
  output logic [ROB_BIT-1:0] alu_rob_entry
);
  localparam int unsigned RS_SIZE = 1 << RS_BIT;

  typedef struct packed {
    logic [2:0]         op;
    logic [6:0]         op_type;
    logic               op_addition;
    logic [31:0]        vi;
    logic [31:0]        vj;
    logic               qi_valid;
    logic               qj_valid;
    logic [ROB_BIT-1:0] qi;
    logic [ROB_BIT-1:0] qj;
    logic [ROB_BIT-1:0] rob_entry;
  } entry_t;

  logic [RS_SIZE-1:0] busy;
  entry_t             ent [RS_SIZE];

  logic               free_found;
  logic [RS_BIT-1:0]  free_idx;
  logic               issue_found;
  logic [RS_BIT-1:0]  issue_idx;
  logic               disp_qi_valid;
  logic               disp_qj_valid;
  logic [31:0]        disp_vi;
  logic [31:0]        disp_vj;

  assign full = &busy;

  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    issue_found = 1'b0;
    issue_idx   = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (!busy[RS_BIT'(i)] && !free_found) begin
        free_found = 1'b1;
        free_idx   = RS_BIT'(i);
      end
      if (busy[RS_BIT'(i)] && !ent[RS_BIT'(i)].qi_valid && !ent[RS_BIT'(i)].qj_valid
          && !issue_found) begin
        issue_found = 1'b1;
        issue_idx   = RS_BIT'(i);
      end
    end
  end

  // Incoming operands are snooped too, so a tag broadcast during dispatch is not lost.
  always_comb begin
    disp_qi_valid = in_qi_valid;
    disp_vi       = in_vi;
    disp_qj_valid = in_qj_valid;
    disp_vj       = in_vj;
    if (in_qi_valid) begin
      if (alu_cdb_valid && alu_cdb_entry == in_qi) begin
        disp_qi_valid = 1'b0;
        disp_vi       = alu_cdb_value;
      end else if (lsb_cdb_valid && lsb_cdb_entry == in_qi) begin
        disp_qi_valid = 1'b0;
        disp_vi       = lsb_cdb_value;
      end
    end
    if (in_qj_valid) begin
      if (alu_cdb_valid && alu_cdb_entry == in_qj) begin
        disp_qj_valid = 1'b0;
        disp_vj       = alu_cdb_value;
      end else if (lsb_cdb_valid && lsb_cdb_entry == in_qj) begin
        disp_qj_valid = 1'b0;
        disp_vj       = lsb_cdb_value;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || rob_clear_up) begin
      busy            <= '0;
      alu_valid       <= 1'b0;
      alu_vi          <= '0;
      alu_vj          <= '0;
      alu_op          <= '0;
      alu_op_type     <= '0;
      alu_op_addition <= 1'b0;
      alu_rob_entry   <= '0;
    end else if (rdy_in) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (busy[RS_BIT'(i)] && ent[RS_BIT'(i)].qi_valid) begin
          if (alu_cdb_valid && alu_cdb_entry == ent[RS_BIT'(i)].qi) begin
            ent[RS_BIT'(i)].vi       <= alu_cdb_value;
            ent[RS_BIT'(i)].qi_valid <= 1'b0;
          end else if (lsb_cdb_valid && lsb_cdb_entry == ent[RS_BIT'(i)].qi) begin
            ent[RS_BIT'(i)].vi       <= lsb_cdb_value;
            ent[RS_BIT'(i)].qi_valid <= 1'b0;
          end
        end
        if (busy[RS_BIT'(i)] && ent[RS_BIT'(i)].qj_valid) begin
          if (alu_cdb_valid && alu_cdb_entry == ent[RS_BIT'(i)].qj) begin
            ent[RS_BIT'(i)].vj       <= alu_cdb_value;
            ent[RS_BIT'(i)].qj_valid <= 1'b0;
          end else if (lsb_cdb_valid && lsb_cdb_entry == ent[RS_BIT'(i)].qj) begin
            ent[RS_BIT'(i)].vj       <= lsb_cdb_value;
            ent[RS_BIT'(i)].qj_valid <= 1'b0;
          end
        end
      end

      if (issue_found) begin
        alu_valid         <= 1'b1;
        alu_vi            <= ent[issue_idx].vi;
        alu_vj            <= ent[issue_idx].vj;
        alu_op            <= ent[issue_idx].op;
        alu_op_type       <= ent[issue_idx].op_type;
        alu_op_addition   <= ent[issue_idx].op_addition;
        alu_rob_entry     <= ent[issue_idx].rob_entry;
        busy[issue_idx]   <= 1'b0;
      end else begin
        alu_valid <= 1'b0;
      end

      // The dispatch slot is free at cycle start, so it never collides with the issue slot.
      if (in_valid && free_found) begin
        busy[free_idx]          <= 1'b1;
        ent[free_idx].op        <= in_op;
        ent[free_idx].op_type   <= in_op_type;
        ent[free_idx].op_addition <= in_op_addition;
        ent[free_idx].vi        <= disp_vi;
        ent[free_idx].vj        <= disp_vj;
        ent[free_idx].qi_valid  <= disp_qi_valid;
        ent[free_idx].qj_valid  <= disp_qj_valid;
        ent[free_idx].qi        <= in_qi;
        ent[free_idx].qj        <= in_qj;
        ent[free_idx].rob_entry <= in_rob_entry;
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: a slot-level reference model pushes the expected
// issue bundle for every clock edge; an independent monitor pops and compares.
module tb_alu_rs;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_clear_up, in_valid;
  logic [2:0]  in_op;
  logic [6:0]  in_op_type;
  logic        in_op_addition;
  logic [31:0] in_vi, in_vj;
  logic        in_qi_valid, in_qj_valid;
  logic [3:0]  in_qi, in_qj, in_rob_entry;
  logic        full;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_entry, lsb_cdb_entry;
  logic [31:0] alu_cdb_value, lsb_cdb_value;
  logic        alu_valid;
  logic [31:0] alu_vi, alu_vj;
  logic [2:0]  alu_op;
  logic [6:0]  alu_op_type;
  logic        alu_op_addition;
  logic [3:0]  alu_rob_entry;

  always #5 clk_in = ~clk_in;

  alu_rs #(.RS_BIT(3), .ROB_BIT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear_up(rob_clear_up),
    .in_valid(in_valid), .in_op(in_op), .in_op_type(in_op_type),
    .in_op_addition(in_op_addition), .in_vi(in_vi), .in_vj(in_vj),
    .in_qi_valid(in_qi_valid), .in_qj_valid(in_qj_valid), .in_qi(in_qi), .in_qj(in_qj),
    .in_rob_entry(in_rob_entry), .full(full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_entry(alu_cdb_entry), .alu_cdb_value(alu_cdb_value),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_entry(lsb_cdb_entry), .lsb_cdb_value(lsb_cdb_value),
    .alu_valid(alu_valid), .alu_vi(alu_vi), .alu_vj(alu_vj), .alu_op(alu_op),
    .alu_op_type(alu_op_type), .alu_op_addition(alu_op_addition), .alu_rob_entry(alu_rob_entry)
  );

  typedef struct {
    bit          busy;
    logic [2:0]  op;
    logic [6:0]  ty;
    logic        add;
    logic [31:0] vi, vj;
    bit          qiv, qjv;
    logic [3:0]  qi, qj, rob;
  } slot_t;

  typedef struct {
    logic        valid;
    logic [31:0] vi, vj;
    logic [2:0]  op;
    logic [6:0]  ty;
    logic        add;
    logic [3:0]  rob;
  } bund_t;

  slot_t m [8];
  bund_t mb;
  bund_t expq [$];
  int    tests = 0;
  int    fails = 0;

  function automatic slot_t snoop_slot(slot_t s);
    if (s.qiv) begin
      if (alu_cdb_valid && alu_cdb_entry == s.qi) begin s.vi = alu_cdb_value; s.qiv = 0; end
      else if (lsb_cdb_valid && lsb_cdb_entry == s.qi) begin s.vi = lsb_cdb_value; s.qiv = 0; end
    end
    if (s.qjv) begin
      if (alu_cdb_valid && alu_cdb_entry == s.qj) begin s.vj = alu_cdb_value; s.qjv = 0; end
      else if (lsb_cdb_valid && lsb_cdb_entry == s.qj) begin s.vj = lsb_cdb_value; s.qjv = 0; end
    end
    return s;
  endfunction

  function automatic int busy_count();
    int n = 0;
    for (int i = 0; i < 8; i++) if (m[i].busy) n++;
    return n;
  endfunction

  // Apply the model for the coming edge, queue its expected bundle, advance one cycle.
  task automatic tick();
    int    iss, fr;
    slot_t s;
    if (!rst_in) begin
      tests++;
      if (full !== (busy_count() == 8)) begin
        fails++;
        $display("FAIL full t=%0t act=%0b exp=%0b", $time, full, busy_count() == 8);
      end
    end
    if (rst_in || rob_clear_up) begin
      for (int i = 0; i < 8; i++) m[i].busy = 0;
      mb = '{default: 0};
    end else if (rdy_in) begin
      iss = -1;
      fr  = -1;
      for (int i = 0; i < 8; i++) begin
        if (m[i].busy && !m[i].qiv && !m[i].qjv && iss < 0) iss = i;
        if (!m[i].busy && fr < 0) fr = i;
      end
      for (int i = 0; i < 8; i++) if (m[i].busy) m[i] = snoop_slot(m[i]);
      if (iss >= 0) begin
        mb.valid = 1; mb.vi = m[iss].vi; mb.vj = m[iss].vj; mb.op = m[iss].op;
        mb.ty = m[iss].ty; mb.add = m[iss].add; mb.rob = m[iss].rob;
        m[iss].busy = 0;
      end else begin
        mb.valid = 0;
      end
      if (in_valid && fr >= 0) begin
        s.busy = 1; s.op = in_op; s.ty = in_op_type; s.add = in_op_addition;
        s.vi = in_vi; s.vj = in_vj; s.qiv = in_qi_valid; s.qjv = in_qj_valid;
        s.qi = in_qi; s.qj = in_qj; s.rob = in_rob_entry;
        m[fr] = snoop_slot(s);
      end
    end
    expq.push_back(mb);
    @(negedge clk_in);
  endtask

  task automatic idle();
    rdy_in = 1; rob_clear_up = 0; in_valid = 0; in_op = '0; in_op_type = '0;
    in_op_addition = 0; in_vi = '0; in_vj = '0; in_qi_valid = 0; in_qj_valid = 0;
    in_qi = '0; in_qj = '0; in_rob_entry = '0;
    alu_cdb_valid = 0; alu_cdb_entry = '0; alu_cdb_value = '0;
    lsb_cdb_valid = 0; lsb_cdb_entry = '0; lsb_cdb_value = '0;
  endtask

  task automatic dispatch(input logic [2:0] op, input logic [6:0] ty, input logic add,
                          input logic [31:0] vi, input logic [31:0] vj,
                          input logic qiv, input logic [3:0] qi,
                          input logic qjv, input logic [3:0] qj, input logic [3:0] rob);
    in_valid = 1; in_op = op; in_op_type = ty; in_op_addition = add; in_vi = vi; in_vj = vj;
    in_qi_valid = qiv; in_qi = qi; in_qj_valid = qjv; in_qj = qj; in_rob_entry = rob;
  endtask

  // Monitor: one expected bundle per edge, compared a little after the edge.
  initial begin
    bund_t e;
    forever begin
      @(posedge clk_in);
      #1;
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty t=%0t act_valid=%0b", $time, alu_valid);
      end else begin
        e = expq.pop_front();
        if (alu_valid !== e.valid || alu_vi !== e.vi || alu_vj !== e.vj || alu_op !== e.op ||
            alu_op_type !== e.ty || alu_op_addition !== e.add || alu_rob_entry !== e.rob) begin
          fails++;
          $display("FAIL issue t=%0t act v=%0b vi=%h vj=%h op=%0d ty=%b add=%0b rob=%0d exp v=%0b vi=%h vj=%h op=%0d ty=%b add=%0b rob=%0d",
                   $time, alu_valid, alu_vi, alu_vj, alu_op, alu_op_type, alu_op_addition,
                   alu_rob_entry, e.valid, e.vi, e.vj, e.op, e.ty, e.add, e.rob);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t act=running exp=finished", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) m[i] = '{default: 0};
    mb = '{default: 0};
    idle();
    rst_in = 1;
    tick(); tick();
    rst_in = 0;
    idle(); tick();

    // add with both operands ready
    dispatch(3'd0, 7'b0110011, 1'b0, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3); tick();
    idle(); tick(); tick();

    // sub waiting on tag 2, broadcast two cycles later
    dispatch(3'd0, 7'b0110011, 1'b1, 32'd0, 32'd9, 1'b1, 4'd2, 1'b0, 4'd0, 4'd4); tick();
    idle(); tick();
    alu_cdb_valid = 1; alu_cdb_entry = 4'd2; alu_cdb_value = 32'd100; tick();
    idle(); tick(); tick();

    // qj tag broadcast on the load bus in the dispatch cycle
    dispatch(3'd5, 7'b0010011, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 4'd0, 1'b1, 4'd6, 4'd5);
    lsb_cdb_valid = 1; lsb_cdb_entry = 4'd6; lsb_cdb_value = 32'hFFFF_FFFF; tick();
    idle(); tick(); tick();

    // fill all slots; entries 1 and 4 share tag 9; ninth dispatch must be dropped
    for (int i = 0; i < 8; i++) begin
      idle();
      dispatch(3'(i), 7'b1100011, 1'b0, 32'(i), 32'(i * 3), 1'b1, (i == 1 || i == 4) ? 4'd9 : 4'd12,
               1'b0, 4'd0, 4'(i));
      tick();
    end
    idle();
    dispatch(3'd7, 7'b0110011, 1'b0, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15); tick();
    idle(); alu_cdb_valid = 1; alu_cdb_entry = 4'd9; alu_cdb_value = 32'd55; tick();
    idle(); tick(); tick(); tick();
    rob_clear_up = 1; tick();

    // flush with a concurrent dispatch, then broadcast the stale tags
    for (int i = 1; i <= 3; i++) begin
      idle();
      dispatch(3'd1, 7'b0110011, 1'b0, 32'd0, 32'd2, 1'b1, 4'(i), 1'b0, 4'd0, 4'(i + 8));
      tick();
    end
    idle(); rob_clear_up = 1;
    dispatch(3'd2, 7'b0110011, 1'b0, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7); tick();
    idle(); alu_cdb_valid = 1; alu_cdb_entry = 4'd1; alu_cdb_value = 32'd11; tick();
    idle(); alu_cdb_valid = 1; alu_cdb_entry = 4'd3; lsb_cdb_valid = 1; lsb_cdb_entry = 4'd2; tick();
    idle(); tick(); tick();

    // ready instruction paused three cycles; inputs during the pause must be ignored
    dispatch(3'd4, 7'b0110011, 1'b0, 32'd21, 32'd22, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6); tick();
    for (int i = 0; i < 3; i++) begin
      idle(); rdy_in = 0;
      dispatch(3'd6, 7'b0010011, 1'b0, 32'd99, 32'd98, 1'b0, 4'd0, 1'b0, 4'd0, 4'd13);
      alu_cdb_valid = 1; alu_cdb_entry = 4'd13;
      tick();
    end
    idle(); tick(); tick(); tick();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      idle();
      rdy_in = ($urandom_range(7) != 0);
      rob_clear_up = ($urandom_range(63) == 0);
      if (busy_count() < 8 && $urandom_range(1) == 1) begin
        dispatch(3'($urandom_range(7)),
                 ($urandom_range(2) == 0) ? 7'b0010011 : (($urandom_range(1) == 0) ? 7'b0110011 : 7'b1100011),
                 1'($urandom_range(1)), $urandom, $urandom,
                 1'($urandom_range(1)), 4'($urandom_range(15)),
                 1'($urandom_range(1)), 4'($urandom_range(15)), 4'($urandom_range(15)));
      end
      if ($urandom_range(1) == 1) begin
        alu_cdb_valid = 1; alu_cdb_entry = 4'($urandom_range(15)); alu_cdb_value = $urandom;
      end
      if ($urandom_range(2) == 0) begin
        lsb_cdb_valid = 1; lsb_cdb_entry = 4'($urandom_range(15)); lsb_cdb_value = $urandom;
        if (alu_cdb_valid && lsb_cdb_entry == alu_cdb_entry) lsb_cdb_entry = lsb_cdb_entry ^ 4'd1;
      end
      tick();
    end
    idle(); tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
